// File: rtl/sfx_mixer_apu_if.sv
// Bundle between the game core and the sound-effect mixer: event inputs, per-channel
// tone settings, the mute control and the mixed audio outputs.
interface sfx_mixer_apu_if #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int DUR_W    = 6
);
  localparam int LVL_W = VOL_W + $clog2(NUM_CH);

  logic [NUM_CH-1:0]          trigger;
  logic                       frame_tick;
  logic [NUM_CH*PERIOD_W-1:0] ch_period;
  logic [NUM_CH*DUR_W-1:0]    ch_dur;
  logic                       mute;
  logic [NUM_CH-1:0]          active;
  logic [LVL_W-1:0]           level;
  logic                       sound;

  modport master (
    output trigger, frame_tick, ch_period, ch_dur, mute,
    input  active, level, sound
  );

  modport slave (
    input  trigger, frame_tick, ch_period, ch_dur, mute,
    output active, level, sound
  );
endinterface

// File: rtl/sfx_mixer_apu.sv
// Multi-channel square-tone sound-effect generator with sustain/decay envelopes,
// a registered amplitude mixer and a first-order sigma-delta 1-bit output.
module sfx_mixer_apu #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int DUR_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  sfx_mixer_apu_if.slave   bus
);
  localparam int LVL_W = VOL_W + $clog2(NUM_CH);
  localparam logic [VOL_W-1:0] VMAX = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [NUM_CH-1:0]   trig_q;
  logic [NUM_CH-1:0]   rise;
  logic [0:0]          state   [NUM_CH];
  logic [DUR_W-1:0]    dur_cnt [NUM_CH];
  logic [VOL_W-1:0]    vol     [NUM_CH];
  logic [PERIOD_W-1:0] phase   [NUM_CH];
  logic [PERIOD_W-1:0] period  [NUM_CH];
  logic [DUR_W-1:0]    dur_ld  [NUM_CH];
  logic [NUM_CH-1:0]   sq;
  logic [NUM_CH-1:0]   active;

  logic [LVL_W-1:0]    amp_sum;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    acc;
  logic [LVL_W:0]      acc_sum;
  logic                sound;

  assign rise = bus.trigger & ~trig_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      period[i] = bus.ch_period[i*PERIOD_W +: PERIOD_W];
      dur_ld[i] = bus.ch_dur[i*DUR_W +: DUR_W];
      active[i] = (state[i] == ST_PLAY);
    end
  end

  // Channel stage: edge detect, tone phase and envelope per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= '1;
      sq     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]   <= ST_IDLE;
        dur_cnt[i] <= '0;
        vol[i]     <= '0;
        phase[i]   <= '0;
      end
    end else begin
      trig_q <= bus.trigger;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i]) begin
          // A fresh event wins over a coincident frame tick; a zero period stays silent.
          state[i]   <= ST_PLAY;
          dur_cnt[i] <= dur_ld[i];
          vol[i]     <= VMAX;
          phase[i]   <= '0;
          sq[i]      <= (period[i] != '0);
        end else if (state[i] == ST_PLAY) begin
          if (period[i] == '0) begin
            sq[i] <= 1'b0;
          end else if (phase[i] >= period[i] - PERIOD_W'(1)) begin
            phase[i] <= '0;
            sq[i]    <= ~sq[i];
          end else begin
            phase[i] <= phase[i] + PERIOD_W'(1);
          end

          if (bus.frame_tick) begin
            if (dur_cnt[i] != '0) begin
              dur_cnt[i] <= dur_cnt[i] - DUR_W'(1);
            end else if (vol[i] > VOL_W'(1)) begin
              vol[i] <= vol[i] - VOL_W'(1);
            end else begin
              vol[i]   <= '0;
              sq[i]    <= 1'b0;
              state[i] <= ST_IDLE;
            end
          end
        end else begin
          vol[i] <= '0;
          sq[i]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    amp_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state[i] == ST_PLAY && sq[i]) begin
        amp_sum = amp_sum + LVL_W'(vol[i]);
      end
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, level};

  // Mixer and modulator stage: registered sum, then accumulator carry as the audio bit
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      acc   <= '0;
      sound <= 1'b0;
    end else begin
      level <= bus.mute ? '0 : amp_sum;
      acc   <= acc_sum[LVL_W-1:0];
      sound <= acc_sum[LVL_W];
    end
  end

  assign bus.active = active;
  assign bus.level  = level;
  assign bus.sound  = sound;
endmodule

// File: doc/sfx_mixer_apu.md
# sfx_mixer_apu

Parametrised multi-channel sound-effect generator and 1-bit mixer, the successor to the single-output game APU used alongside the VGA sync generator. Each of `NUM_CH` channels is fired by a game-event input (collision flags from the game core), plays a square tone with a sustain-then-linear-decay envelope, and the channel amplitudes are summed and converted to a single pulse-density audio bit by a first-order sigma-delta modulator. It sits between the game logic, the frame timing (`frame_tick` from vsync) and the `sound` pin on the audio PMOD.

## Interface
- `NUM_CH`, 3: number of channels (≥1)
- `PERIOD_W`, 12: half-period counter width (clk cycles)
- `VOL_W`, 4: per-channel volume width; max volume `VMAX = 2^VOL_W-1`
- `DUR_W`, 6: sustain duration width (frames)
- Derived: `LVL_W = VOL_W + $clog2(NUM_CH)`

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `trigger`  in  NUM_CH  per-channel event inputs; rising edge starts or restarts a channel
- `frame_tick`  in  1  one-cycle pulse per video frame; envelope time base
- `ch_period`  in  NUM_CH*PERIOD_W  per-channel half-period; channel i at bits [i*PERIOD_W +: PERIOD_W]
- `ch_dur`  in  NUM_CH*DUR_W  per-channel sustain length in frames, same packing
- `mute`  in  1  forces mixer output silent; channels keep running
- `active`  out  NUM_CH  channel i is in PLAY
- `level`  out  LVL_W  registered mixed amplitude
- `sound`  out  1  sigma-delta audio bit

## Operation
- Edge detect: `trig_q` registers `trigger`; rise = `trigger & ~trig_q`. `trig_q` resets to all ones, so an input held high through reset never fires.
- Per-channel FSM, states IDLE and PLAY:
  - Rise in any state → PLAY, load `dur_cnt = ch_dur`, `vol = VMAX`, `phase = 0`, `sq = 1`. Rise takes priority over a coincident `frame_tick` for that channel; the tick is ignored.
  - PLAY, every clk: if `phase >= ch_period-1`, then `phase = 0` and `sq` toggles; else `phase++`. The `>=` compare makes a period reduced mid-note wrap immediately.
  - `ch_period == 0`: `sq` is held at 0 (silent). Phase logic idles; the envelope still runs.
  - PLAY, on `frame_tick`: if `dur_cnt != 0`, decrement it; else if `vol > 1`, decrement `vol`; else `vol = 0`, `sq = 0`, go to IDLE.
  - `ch_dur == 0`: decay starts on the first tick.
  - IDLE: `vol = 0`, `sq = 0`, counters hold.
- Amplitude: `amp_i = (PLAY && sq) ? vol : 0`.
- Mixer: `level <= mute ? 0 : Σ amp_i`, zero-extended to LVL_W. The sum cannot overflow: max is `NUM_CH*VMAX`.
- Modulator: `{carry, acc} <= acc + level`, with `acc` LVL_W bits. `sound <= carry`. Over 2^LVL_W cycles at constant level L, `sound` is high exactly L times.
- Reset: every channel IDLE, `dur_cnt`/`vol`/`phase`/`sq` = 0, `acc = 0`, `level = 0`, `sound = 0`, `active = 0`, `trig_q = all ones`. Reset mid-note aborts immediately.

## Timing
- Trigger high at cycle t (low at t-1): channel state (`active[i]` = 1, `vol` = VMAX, `sq` = 1) visible at t+1. The amplitude contribution appears in `level` at t+2 and first affects `sound` at t+3.
- First `sq` toggle happens `ch_period` cycles after entering PLAY; half-period is exactly `ch_period` clk.
- `frame_tick` at cycle t updates `dur_cnt`/`vol` at t+1; `active` clears at t+1 on the final tick.
- `mute` takes effect on `level` one cycle after assertion and on `sound` one cycle after that.
- Total note length in frames: `ch_dur + VMAX` ticks from start to IDLE.

## Test plan
- Reset with `trigger = 3'b111` held for 2 cycles, then released from reset with trigger still high → `active = 0`, `level = 0`, `sound = 0`; a later fall then rise starts the channels.
- Ch0 with `ch_period = 4`, `ch_dur = 2`, one-cycle pulse on `trigger[0]` → `active[0]` at t+1. `level` alternates 15 and 0 in 4-cycle runs starting at t+2. `vol` goes to 14 on tick 3 and reaches 0 with `active[0] = 0` after tick 17.
- All three channels triggered together with `ch_period = 1000` → `level = 45`. Over a 64-cycle window `sound` is high exactly 45 times.
- Ch1 retriggered while `vol = 5`, with `frame_tick` in the same cycle → next cycle `vol = 15`, `dur_cnt = ch_dur`, `phase = 0`; the tick has no effect.
- `mute` asserted while ch0 is playing → `level = 0` next cycle and `sound` stays 0 (after 1 cycle flush) while `active[0]` stays 1. Deassert → `level` returns to the current `amp_0`.
- `ch_period = 0` on ch2, triggered → `active[2] = 1`, contribution 0 throughout; returns to IDLE after `ch_dur + 15` ticks.
